// File: rtl/fma_share_pkg.sv
// rtl/fma_share_pkg.sv - shared types and constants for the FMA sharing controller
package fma_share_pkg;

    // Which requester owns an operation in flight.
    typedef enum logic {
        OWN_FPU = 1'b0,
        OWN_DIV = 1'b1
    } owner_t;

    // Width of the optional performance counters.
    localparam int PERF_W = 16;

    // Saturating increment used by the performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fma_share_rr.sv
// rtl/fma_share_rr.sv - two-way round-robin arbiter with last-grant pointer
module fma_share_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Grant: a lone eligible requester wins; a tie goes to the one not granted last tie.
    always_comb begin
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;
        if (en) begin
            if (&eligible) begin
                gnt        = last_gnt_q ? 2'b01 : 2'b10;
                last_gnt_d = ~last_gnt_q;
            end else begin
                gnt = eligible;
            end
        end
    end

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/fma_share_ctrl.sv
// rtl/fma_share_ctrl.sv - FMA pipeline sharing controller; FMA_SHARE_PERF_EN adds perf counters
module fma_share_ctrl
    import fma_share_pkg::*;
#(
    parameter int LAT  = 3,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [TAGW-1:0]   req0_tag,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [TAGW-1:0]   req1_tag,
    output logic              req1_ready,
    input  logic              flush0,
    input  logic              flush1,
    output logic              fma_issue,
    output logic              fma_sel,
    output logic              fma_stall,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              idle,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_stall
);

    // One tracking entry per FMA pipeline stage.
    typedef struct packed {
        logic            valid;
        owner_t          owner;
        logic [TAGW-1:0] tag;
    } stg_t;

    stg_t            stg_q [LAT];
    stg_t            stg_d [LAT];
    stg_t            head;
    logic [1:0]      flush_v;
    logic [1:0]      rsp_rdy_v;
    logic [1:0]      elig;
    logic [1:0]      gnt;
    logic            frz;
    logic            arb_en;
    logic            any_gnt;
    logic [TAGW-1:0] win_tag;
    logic            fma_sel_q;
    logic            fma_sel_d;

    assign head      = stg_q[LAT-1];
    assign flush_v   = {flush1, flush0};
    assign rsp_rdy_v = {rsp1_ready, rsp0_ready};

    // Freeze when the head result is neither taken nor flushed by its owner.
    always_comb begin
        frz     = head.valid & ~rsp_rdy_v[head.owner] & ~flush_v[head.owner];
        arb_en  = ~frz;
        elig    = {req1_valid & ~flush1, req0_valid & ~flush0};
        any_gnt = |gnt;
        win_tag = gnt[1] ? req1_tag : req0_tag;
    end

    fma_share_rr u_rr (
        .clk      (clk),
        .reset    (reset),
        .eligible (elig),
        .en       (arb_en),
        .gnt      (gnt)
    );

    // Next stage contents: shift when unfrozen, then kill flushed owners' entries.
    always_comb begin
        stg_d = stg_q;
        if (!frz) begin
            for (int i = LAT - 1; i > 0; i--) begin
                stg_d[i] = stg_q[i-1];
            end
            stg_d[0].valid = any_gnt;
            stg_d[0].owner = any_gnt ? owner_t'(gnt[1]) : OWN_FPU;
            stg_d[0].tag   = any_gnt ? win_tag : '0;
        end
        for (int i = 0; i < LAT; i++) begin
            if (stg_d[i].valid && flush_v[stg_d[i].owner]) begin
                stg_d[i].valid = 1'b0;
            end
        end
    end

    // Operand select follows the winner and otherwise keeps its last value.
    always_comb begin
        fma_sel_d = any_gnt ? gnt[1] : fma_sel_q;
    end

    // Stage tracking and operand-select registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                stg_q[i] <= '0;
            end
            fma_sel_q <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            fma_sel_q <= fma_sel_d;
        end
    end

    // Handshake, pipeline-control and status outputs.
    always_comb begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        fma_issue  = any_gnt;
        fma_sel    = fma_sel_d;
        fma_stall  = frz;
        rsp0_valid = head.valid & (head.owner == OWN_FPU) & ~flush0;
        rsp1_valid = head.valid & (head.owner == OWN_DIV) & ~flush1;
        rsp_tag    = head.tag;
        idle       = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            if (stg_q[i].valid) begin
                idle = 1'b0;
            end
        end
    end

`ifdef FMA_SHARE_PERF_EN
    logic [PERF_W-1:0] perf_conflict_q;
    logic [PERF_W-1:0] perf_conflict_d;
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_stall_d;

    // Count contended-issue cycles and frozen cycles, saturating.
    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_stall_d    = perf_stall_q;
        if ((&elig) && !frz) begin
            perf_conflict_d = sat_inc(perf_conflict_q);
        end
        if (frz) begin
            perf_stall_d = sat_inc(perf_stall_q);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conflict_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_conflict = perf_conflict_q;
    assign perf_stall    = perf_stall_q;
`else
    assign perf_conflict = '0;
    assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_fma_share_ctrl.sv
// tb/tb_fma_share_ctrl.sv - randomized self-checking bench with an op-list reference model
module tb_fma_share_ctrl;

    localparam int LAT  = 3;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [TAGW-1:0] req0_tag, req1_tag, rsp_tag;
    logic            flush0, flush1;
    logic            fma_issue, fma_sel, fma_stall;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic            idle;
    logic [15:0]     perf_conflict, perf_stall;

    always #5 clk = ~clk;

    fma_share_ctrl #(.LAT(LAT), .TAGW(TAGW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_tag      (req0_tag),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_tag      (req1_tag),
        .req1_ready    (req1_ready),
        .flush0        (flush0),
        .flush1        (flush1),
        .fma_issue     (fma_issue),
        .fma_sel       (fma_sel),
        .fma_stall     (fma_stall),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp_tag       (rsp_tag),
        .idle          (idle),
        .perf_conflict (perf_conflict),
        .perf_stall    (perf_stall)
    );

    // Reference model: a list of in-flight operations, each aged by unfrozen cycles.
    typedef struct {
        int own;
        int tag;
        int age;
    } op_t;

    op_t mq[$];
    int  m_last, m_sel, m_conf, m_stall;
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_last  = 1;
        m_sel   = 0;
        m_conf  = 0;
        m_stall = 0;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_tag = 0; req1_valid = 0; req1_tag = 0;
        flush0 = 0; flush1 = 0; rsp0_ready = 1; rsp1_ready = 1;
    endtask

    // Drive one cycle of inputs, check every output against the model, then step the model.
    task automatic cycle(input int v0, input int t0, input int v1, input int t1,
                         input int f0, input int f1, input int r0, input int r1);
        int  hi;
        int  hown;
        bit  frz, e0, e1;
        int  win;
        op_t nq[$];
        op_t fq[$];
        op_t op;
        @(negedge clk);
        req0_valid = v0[0]; req0_tag = t0[TAGW-1:0];
        req1_valid = v1[0]; req1_tag = t1[TAGW-1:0];
        flush0 = f0[0]; flush1 = f1[0]; rsp0_ready = r0[0]; rsp1_ready = r1[0];
        #1;
        hi = -1;
        foreach (mq[i]) if (mq[i].age == LAT - 1) hi = i;
        hown = (hi >= 0) ? mq[hi].own : 0;
        frz  = (hi >= 0) && !((hown == 0) ? (r0 != 0 || f0 != 0) : (r1 != 0 || f1 != 0));
        e0   = (v0 != 0) && (f0 == 0);
        e1   = (v1 != 0) && (f1 == 0);
        win  = -1;
        if (!frz) begin
            if (e0 && e1) win = 1 - m_last;
            else if (e0)  win = 0;
            else if (e1)  win = 1;
        end
        check("rsp0_valid", rsp0_valid, (hi >= 0 && hown == 0 && f0 == 0) ? 1 : 0);
        check("rsp1_valid", rsp1_valid, (hi >= 0 && hown == 1 && f1 == 0) ? 1 : 0);
        if (hi >= 0) check("rsp_tag", rsp_tag, mq[hi].tag);
        check("fma_stall",  fma_stall,  frz ? 1 : 0);
        check("req0_ready", req0_ready, (win == 0) ? 1 : 0);
        check("req1_ready", req1_ready, (win == 1) ? 1 : 0);
        check("fma_issue",  fma_issue,  (win >= 0) ? 1 : 0);
        check("fma_sel",    fma_sel,    (win >= 0) ? win : m_sel);
        check("idle",       idle,       (mq.size() == 0) ? 1 : 0);
`ifdef FMA_SHARE_PERF_EN
        check("perf_conflict", perf_conflict, m_conf);
        check("perf_stall",    perf_stall,    m_stall);
`else
        check("perf_conflict", perf_conflict, 0);
        check("perf_stall",    perf_stall,    0);
`endif
        if (!frz) begin
            foreach (mq[i]) begin
                if (i != hi) begin
                    op = mq[i];
                    op.age++;
                    nq.push_back(op);
                end
            end
            if (win >= 0) begin
                op.own = win; op.tag = (win == 1) ? t1 : t0; op.age = 0;
                nq.push_back(op);
            end
        end else begin
            nq = mq;
        end
        foreach (nq[i]) begin
            if (!((nq[i].own == 0 && f0 != 0) || (nq[i].own == 1 && f1 != 0))) fq.push_back(nq[i]);
        end
        mq = fq;
        if (e0 && e1 && !frz && m_conf < 65535) m_conf++;
        if (frz && m_stall < 65535) m_stall++;
        if (win >= 0) m_sel = win;
        if (win >= 0 && e0 && e1) m_last = win;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    int exp_own[4];

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_fma_issue",  fma_issue,  0);
        check("rst_fma_stall",  fma_stall,  0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_fma_sel",    fma_sel,    0);
        check("rst_rsp_tag",    rsp_tag,    0);
        check("rst_idle",       idle,       1);
        check("rst_perf_stall", perf_stall, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single op: issue at cycle 0, response at cycle LAT, idle after.
        cycle(1, 5, 0, 0, 0, 0, 1, 1);
        check("single_issue", fma_issue, 1);
        drain(2);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        check("single_rsp0", rsp0_valid, 1);
        check("single_tag",  rsp_tag,    5);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        check("single_idle", idle, 1);

        // Tie arbitration: alternate grants starting with req0, responses in order.
        exp_own = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            cycle(1, k + 1, 1, k + 1, 0, 0, 1, 1);
            check("tie_gnt0", req0_ready, (exp_own[k] == 0) ? 1 : 0);
            check("tie_sel",  fma_sel,    exp_own[k]);
        end
        check("tie_rsp_first", rsp0_valid, 1);
        for (int k = 1; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, 1);
            check("tie_rsp_own", rsp1_valid, exp_own[k]);
            check("tie_rsp_tag", rsp_tag,    k + 1);
        end
        drain(2);

        // Backpressure: req1 result held two cycles while req0 waits.
        cycle(0, 0, 1, 9, 0, 0, 1, 1);
        drain(LAT - 1);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 3, 0, 0, 0, 0, 1, 0);
            check("bp_stall", fma_stall, 1);
            check("bp_hold",  rsp_tag,   9);
        end
        cycle(1, 3, 0, 0, 0, 0, 1, 1);
        check("bp_release", req0_ready, 1);
        drain(LAT + 1);

        // Flush: three req0 ops killed, req1 issued on the flush cycle still responds.
        for (int k = 0; k < 3; k++) cycle(1, k + 1, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 7, 1, 0, 1, 1);
        check("fl_no_rsp0", rsp0_valid, 0);
        check("fl_gnt1",    req1_ready, 1);
        drain(LAT - 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        check("fl_rsp1", rsp1_valid, 1);
        check("fl_tag",  rsp_tag,    7);
        drain(2);

        // Flush releases a freeze on the req0 head and req1 is granted that cycle.
        cycle(1, 4, 0, 0, 0, 0, 1, 1);
        drain(LAT - 1);
        cycle(0, 0, 1, 6, 0, 0, 0, 1);
        check("ff_frozen", fma_stall, 1);
        cycle(0, 0, 1, 6, 1, 0, 0, 1);
        check("ff_unfrz", fma_stall,  0);
        check("ff_gnt1",  req1_ready, 1);
        drain(LAT + 1);

        // Asynchronous reset between edges with two ops in flight.
        cycle(1, 2, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 3, 0, 0, 1, 1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("ar_rsp0", rsp0_valid, 0);
        check("ar_rsp1", rsp1_valid, 0);
        check("ar_idle", idle,       1);
        model_reset();
        #1;
        reset = 1'b1;
        cycle(1, 1, 1, 2, 0, 0, 1, 1);
        check("ar_tie_req0", req0_ready, 1);
        drain(LAT + 1);

        // Randomized traffic with backpressure and occasional flushes.
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15),
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
        end
        drain(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
